pmt_time_hist: RTL
==================

// Module: pmt_time_hist
// PURPOSE
//  Timing histogrammer feeding the serial command processor's histogram readout.
//  Measures clk ticks from a reference edge (start) to the first PMT hit edge (hit).
//  Bins that delay into NBINS saturating counters, plus two overflow counters.
//  Cleared by the processor's one-cycle resethist pulse issued at readout.
// PARAMETERS
//  NBINS      32  number of timing bins (output array h depth)
//  CNT_W      32  width of every bin/overflow counter
//  BIN_SHIFT  0   log2(ticks per bin); bin = tick_count >> BIN_SHIFT
//  WINDOW     64  ticks after start before the window closes (>= NBINS<<BIN_SHIFT)
// PORTS
//  clk        in   1            system clock
//  rst_n      in   1            reset, asynchronous, active-low
//  start      in   1            async reference pulse (trigger/clock input), rising edge used
//  hit        in   1            async PMT discriminator pulse, rising edge used
//  resethist  in   1            synchronous clear of all counters (one-cycle pulse)
//  h          out  CNT_W x NBINS  bin counters
//  h_out      out  CNT_W x 2    [0]=hits outside any window, [1]=hits in window beyond last bin
//  armed      out  1            high while a window is open and no hit yet taken
// BEHAVIOUR
//  - Reset: h[*]=0, h_out[*]=0, armed=0, tick counter=0, state=IDLE, sync flops=0.
//  - start/hit each pass a 2-flop synchroniser then rising-edge detect (edge = s2 & ~s3).
//  - Latency: pin edge -> edge pulse 3 clks; counter increment visible 1 clk later (4 total).
//  - States:
//    IDLE : start_e -> ARMED, tick=0. hit_e (no start_e) -> h_out[0]++.
//    ARMED: tick++ each clk. hit_e -> bin=tick>>BIN_SHIFT; bin<NBINS ? h[bin]++ : h_out[1]++;
//           go HOLD. tick==WINDOW-1 without hit -> IDLE. armed=1 only here.
//    HOLD : first hit already taken; further hit_e ignored (not counted anywhere);
//           tick++; tick==WINDOW-1 -> IDLE.
//  - start_e in ARMED or HOLD: re-arm, tick=0, state ARMED (previous window abandoned).
//  - start_e and hit_e same clk (any state): hit counted as bin 0 of the new window, state HOLD.
//  - hit_e same clk as timeout: hit counted in bin of tick==WINDOW-1 (or h_out[1]), then IDLE.
//  - Counters saturate at 2^CNT_W-1; never wrap.
//  - resethist=1: all h[*], h_out[*] cleared to 0 that clk; any increment that same clk is
//    dropped (clear wins). State machine and tick counter unaffected.
//  - Only one counter increments per clk (at most one hit_e per clk).
//  - rst_n assertion mid-window: everything returns to reset values immediately; no partial
//    increment. Deassertion: first usable edge requires fresh synchroniser fill (3 clks).
//  - tick width = clog2(WINDOW); bin index compare done at full tick width before indexing.
// STRUCTURE
//  - Package hist_pkg: NBINS, CNT_W defaults, state enum {IDLE,ARMED,HOLD}, counter typedef
//    cnt_t = logic [CNT_W-1:0] shared with the serial processor readout.
//  - Sub-module edge_sync: 2-flop synchroniser + rising-edge pulse, instantiated twice.
//  - Top holds FSM, tick counter, counter array with single saturating incrementer.
// TESTING
//  1 Reset: drive rst_n=0 mid-window with h[3]=5 -> all h/h_out=0, armed=0 within same clk.
//  2 start edge, hit edge 10 clks later (BIN_SHIFT=0) -> h[10]==1, all others 0, state HOLD.
//  3 hit with no start -> h_out[0]==1; hit at tick 40 (WINDOW=64,NBINS=32) -> h_out[1]==1.
//  4 three hits in one window at ticks 5,7,9 -> h[5]==1 only; next start re-arms, hit@7 -> h[7]==1.
//  5 start+hit same clk -> h[0]==1; hit on tick 63 -> h_out[1]++, then IDLE next clk.
//  6 preload h[2]=2^32-1, hit at tick 2 -> stays 2^32-1; resethist coincident with hit -> all 0.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared types for the PMT timing histogrammer and the serial readout that consumes it.
package hist_pkg;

  localparam int NBINS_DEF = 32;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_e;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/pmt_time_hist.sv
// Start-to-first-hit delay histogrammer with saturating bin and overflow counters.
//   state | meaning
//   IDLE  | no window open; stray hits count as out-of-window
//   ARMED | window open, waiting for the first hit
//   HOLD  | first hit taken; later hits ignored until the window closes
module pmt_time_hist
  import hist_pkg::*;
#(
  parameter int NBINS     = NBINS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int BIN_SHIFT = 0,
  parameter int WINDOW    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hit,
  input  logic             resethist,
  output logic [CNT_W-1:0] h     [NBINS],
  output logic [CNT_W-1:0] h_out [2],
  output logic             armed
);

  localparam int TICK_W = $clog2(WINDOW);
  localparam int NCNT   = NBINS + 2;
  localparam int IDX_W  = $clog2(NCNT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0]  IDX_OV0   = IDX_W'(NBINS);
  localparam logic [IDX_W-1:0]  IDX_OV1   = IDX_W'(NBINS + 1);

  logic start_e, hit_e;
  state_e state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d, bin_w;
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic inc_en;
  logic [IDX_W-1:0] inc_idx, hit_idx;

  edge_sync u_start_sync (.clk(clk), .rst_n(rst_n), .din(start), .pulse(start_e));
  edge_sync u_hit_sync   (.clk(clk), .rst_n(rst_n), .din(hit),   .pulse(hit_e));

  assign bin_w   = tick_q >> BIN_SHIFT;
  assign hit_idx = (int'(bin_w) < NBINS) ? IDX_W'(bin_w) : IDX_OV1;

  // The start-edge cycle is tick 0, so the counter enters ARMED already holding 1.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    inc_en  = 1'b0;
    inc_idx = '0;
    if (start_e) begin
      state_d = ARMED;
      tick_d  = TICK_W'(1);
      if (hit_e) begin
        inc_en  = 1'b1;
        inc_idx = '0;
        state_d = HOLD;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_e) begin
            inc_en  = 1'b1;
            inc_idx = IDX_OV0;
          end
        end
        ARMED: begin
          tick_d = tick_q + 1'b1;
          if (hit_e) begin
            inc_en  = 1'b1;
            inc_idx = hit_idx;
            state_d = HOLD;
          end
          if (tick_q == TICK_LAST) state_d = IDLE;
        end
        HOLD: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  // Single shared incrementer; a clear in the same cycle drops the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else if (resethist) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else if (inc_en && (cnt_q[inc_idx] != '1)) begin
      cnt_q[inc_idx] <= cnt_q[inc_idx] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NBINS; i++) h[i] = cnt_q[i];
    h_out[0] = cnt_q[NBINS];
    h_out[1] = cnt_q[NBINS+1];
  end

  assign armed = (state_q == ARMED);

endmodule
